// File: rtl/scan_unload_ctrl.sv
// ============================================================================
// Module      : scan_unload_ctrl
// Description : Unloads the DES round-register scan chain MSB-first and
//               delivers each rebuilt 32-bit image via a 2-entry word buffer.
//               Optional macro SCAN_RECIRC_EN recirculates scan_so -> scan_si.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_unload_ctrl #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             test_mode,
    output logic             scan_si,
    input  logic             scan_so,
    output logic [32:1]      word_data,
    output logic [IDX_W-1:0] word_idx,
    output logic             word_valid,
    input  logic             word_ready
);

    localparam logic [0:0]       c_ST_IDLE  = 1'b0;
    localparam logic [0:0]       c_ST_SHIFT = 1'b1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [4:0]       r_bit_cnt;
    logic [IDX_W-1:0] r_word_cnt;
    logic [32:1]      r_sh;
    logic             r_done;
    logic             r_overflow;

    logic [32:1]      r_mem_data [0:1];
    logic [IDX_W-1:0] r_mem_idx  [0:1];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic             w_shift;
    logic             w_start_acc;
    logic             w_word_done;
    logic             w_last_bit;
    logic [32:1]      w_sh_nxt;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_drop;

    assign w_shift     = (r_state == c_ST_SHIFT);
    assign w_start_acc = (r_state == c_ST_IDLE) && start;
    assign w_word_done = w_shift && (r_bit_cnt == 5'd31);
    assign w_last_bit  = w_word_done && (r_word_cnt == c_LAST_IDX);
    assign w_sh_nxt    = {r_sh[31:1], scan_so};

    // A pop frees the head slot on the same edge, so a full buffer can still take a push.
    assign w_pop     = (r_count != 2'd0) && word_ready;
    assign w_push_ok = w_word_done && ((r_count != 2'd2) || w_pop);
    assign w_drop    = w_word_done && !w_push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start)      w_state_nxt = c_ST_SHIFT;
            c_ST_SHIFT: if (w_last_bit) w_state_nxt = c_ST_IDLE;
            default:                    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_sh       <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= w_last_bit;
            if (w_start_acc) begin
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
                r_overflow <= 1'b0;
            end else if (w_shift) begin
                r_sh      <= w_sh_nxt;
                r_bit_cnt <= r_bit_cnt + 5'd1;
                if (w_word_done) r_word_cnt <= r_word_cnt + c_IDX_ONE;
                if (w_drop)      r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_data[0] <= '0;
            r_mem_data[1] <= '0;
            r_mem_idx[0]  <= '0;
            r_mem_idx[1]  <= '0;
            r_wptr        <= 1'b0;
            r_rptr        <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem_data[r_wptr] <= w_sh_nxt;
                r_mem_idx[r_wptr]  <= r_word_cnt;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign busy       = w_shift;
    assign test_mode  = w_shift;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign word_valid = (r_count != 2'd0);
    assign word_data  = r_mem_data[r_rptr];
    assign word_idx   = r_mem_idx[r_rptr];

`ifdef SCAN_RECIRC_EN
    assign scan_si = w_shift & scan_so;
`else
    assign scan_si = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_scan_unload_ctrl.sv
// ============================================================================
// Module      : tb_scan_unload_ctrl
// Description : Directed/random bench for scan_unload_ctrl with a scan-chain
//               model and a per-register expected word list.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_unload_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 16-register instance
    logic        start16 = 1'b0, ready16 = 1'b0;
    logic        busy16, done16, ovf16, tm16, si16, so16, valid16;
    logic [32:1] data16;
    logic [3:0]  idx16;
    // 1-register instance
    logic        start1 = 1'b0, ready1 = 1'b0;
    logic        busy1, done1, ovf1, tmo1, si1, so1, valid1;
    logic [32:1] data1;
    logic [0:0]  idx1;

    scan_unload_ctrl #(.NUM_REGS(16), .IDX_W(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .busy(busy16), .done(done16),
        .overflow(ovf16), .test_mode(tm16), .scan_si(si16), .scan_so(so16),
        .word_data(data16), .word_idx(idx16), .word_valid(valid16), .word_ready(ready16));

    scan_unload_ctrl #(.NUM_REGS(1), .IDX_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .overflow(ovf1), .test_mode(tmo1), .scan_si(si1), .scan_so(so1),
        .word_data(data1), .word_idx(idx1), .word_valid(valid1), .word_ready(ready1));

    // Chain models: capture image on a start edge with TestMode low, else shift toward scan_so.
    logic [511:0] chain16, img16;
    logic [31:0]  chain1, img1;
    logic         hold16 = 1'b0;
    always @(posedge clk) begin
        if (start16 && !tm16 && !hold16) chain16 <= img16;
        else if (tm16)                   chain16 <= {chain16[510:0], si16};
        if (start1 && !tmo1)             chain1 <= img1;
        else if (tmo1)                   chain1 <= {chain1[30:0], si1};
    end
    assign so16 = chain16[511];
    assign so1  = chain1[31];

    // Monitors sample on the falling edge, clear of the DUT's active edge.
    logic [35:0] obs16[$];
    logic [35:0] obs1[$];
    int tmc16, dnc16, tmc1, dnc1, ovf_at16;
    always @(negedge clk) begin
        if (valid16 && ready16) obs16.push_back({idx16, data16});
        if (valid1 && ready1)   obs1.push_back({3'b000, idx1, data1});
        if (ovf16 && ovf_at16 < 0) ovf_at16 = tmc16;
        tmc16 += int'(tm16);
        dnc16 += int'(done16);
        tmc1  += int'(tmo1);
        dnc1  += int'(done1);
    end

    int total = 0;
    int bad   = 0;
    logic [31:0] regs[16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] obs_at(input int k);
        return (k < obs16.size()) ? obs16[k] : 36'hF_FFFF_FFFF;
    endfunction

    task automatic clear_mon();
        obs16.delete(); obs1.delete();
        tmc16 = 0; dnc16 = 0; tmc1 = 0; dnc1 = 0; ovf_at16 = -1;
    endtask

    task automatic load16();
        for (int k = 0; k < 16; k++) img16[511 - 32*k -: 32] = regs[k];
    endtask

    task automatic pulse_start16();
        start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    task automatic wait_done16(input string tag);
        int n = 0;
        while (done16 !== 1'b1 && n < 800) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n < 800), 64'd1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Expected word list: register k appears with idx k, in chain order.
    task automatic chk_words(input string tag, input logic recirc_zero);
        chk({tag, "_count"}, 64'(obs16.size()), 64'd16);
        for (int k = 0; k < 16; k++)
            chk($sformatf("%s_w%0d", tag, k), 64'(obs_at(k)),
                64'({4'(k), recirc_zero ? 32'h0 : regs[k]}));
        chk({tag, "_tm_cycles"}, 64'(tmc16), 64'd512);
        chk({tag, "_done_pulses"}, 64'(dnc16), 64'd1);
        chk({tag, "_overflow"}, 64'(ovf16), 64'd0);
    endtask

    initial begin
        img16 = '0; img1 = '0; chain16 = '0; chain1 = '0;
        clear_mon();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_outputs16", 64'({tm16, busy16, done16, ovf16, valid16, si16}), 64'd0);
        chk("rst_word16", 64'({idx16, data16}), 64'd0);
        chk("rst_outputs1", 64'({tmo1, busy1, done1, ovf1, valid1, si1}), 64'd0);

        // Single register: DEADBEEF, idx 0, exactly 32 TestMode cycles.
        @(posedge clk); #1;
        clear_mon();
        img1 = 32'hDEADBEEF; ready1 = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        begin
            int n = 0;
            while (done1 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            chk("single_done_seen", 64'(n < 100), 64'd1);
        end
        repeat (5) @(posedge clk); #1;
        chk("single_tm_cycles", 64'(tmc1), 64'd32);
        chk("single_done_pulses", 64'(dnc1), 64'd1);
        chk("single_count", 64'(obs1.size()), 64'd1);
        chk("single_word", 64'(obs1.size() > 0 ? obs1[0] : 36'hF_FFFF_FFFF), 64'h0_DEAD_BEEF);

        // Full chain with reg k = 0x01010101*k and ready always high.
        clear_mon();
        for (int k = 0; k < 16; k++) regs[k] = 32'h01010101 * k;
        load16(); ready16 = 1'b1;
        pulse_start16();
        wait_done16("full_done_seen");
        chk_words("full", 1'b0);

        // Random images with random consumer stalls.
        clear_mon();
        for (int k = 0; k < 16; k++) regs[k] = $urandom;
        load16();
        pulse_start16();
        begin
            int n = 0;
            while (done16 !== 1'b1 && n < 800) begin
                @(posedge clk); #1;
                ready16 = ($urandom_range(0, 3) != 0);
                n++;
            end
            chk("rand_done_seen", 64'(n < 800), 64'd1);
        end
        ready16 = 1'b1;
        repeat (6) @(posedge clk); #1;
        chk_words("rand", 1'b0);

        // Backpressure for the whole unload: idx 0,1 retained, word 2 dropped.
        clear_mon();
        for (int k = 0; k < 16; k++) regs[k] = $urandom;
        load16(); ready16 = 1'b0;
        pulse_start16();
        wait_done16("bp_done_seen");
        chk("bp_overflow", 64'(ovf16), 64'd1);
        chk("bp_overflow_at_word2", 64'(ovf_at16), 64'd96);
        chk("bp_head", 64'({valid16, idx16, data16}), 64'({1'b1, 4'd0, regs[0]}));
        ready16 = 1'b1;
        repeat (6) @(posedge clk); #1;
        chk("bp_popped", 64'(obs16.size()), 64'd2);
        chk("bp_w0", 64'(obs_at(0)), 64'({4'd0, regs[0]}));
        chk("bp_w1", 64'(obs_at(1)), 64'({4'd1, regs[1]}));
        chk("bp_empty", 64'(valid16), 64'd0);

        // Full buffer with push+pop on the same edge, plus a start while busy.
        clear_mon();
        for (int k = 0; k < 16; k++) regs[k] = $urandom;
        load16(); ready16 = 1'b0;
        pulse_start16();
        repeat (95) @(posedge clk);
        #1 ready16 = 1'b1;
        repeat (100) @(posedge clk);
        #1 start16 = 1'b1;
        chk("busy_at_restart", 64'(busy16), 64'd1);
        @(posedge clk); #1;
        start16 = 1'b0;
        chk("busy_after_restart", 64'(busy16), 64'd1);
        wait_done16("edge_done_seen");
        chk_words("edge", 1'b0);

        // Reset mid-shift after an overflow has been flagged.
        clear_mon();
        for (int k = 0; k < 16; k++) regs[k] = $urandom;
        load16(); ready16 = 1'b0;
        pulse_start16();
        repeat (150) @(posedge clk); #1;
        chk("pre_rst_overflow", 64'(ovf16), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_tm_drop", 64'(tm16), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", 64'({tm16, busy16, ovf16, valid16, done16}), 64'd0);
        chk("midrst_word", 64'({idx16, data16}), 64'd0);

        // Two unloads without recapture: recirculated image or all zeros.
        @(posedge clk); #1;
        clear_mon();
        for (int k = 0; k < 16; k++) regs[k] = $urandom;
        load16(); ready16 = 1'b1;
        pulse_start16();
        wait_done16("rc1_done_seen");
        chk_words("rc1", 1'b0);
        clear_mon();
        hold16 = 1'b1;
        pulse_start16();
        wait_done16("rc2_done_seen");
        hold16 = 1'b0;
`ifdef SCAN_RECIRC_EN
        chk_words("rc2", 1'b0);
`else
        chk_words("rc2", 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
